simple_cpu: RTL and testbench
=============================

# simple_cpu

Minimal single-cycle 32-bit CPU with a built-in program ROM that counts upward and drives the count onto a memory-mapped LED output register. It is the top-level demo core for the MAX10 board. The only external visibility is the 32-bit LED port.

## Interface
- DELAY, default 4: delay-loop iteration count loaded by the built-in program (1..32767).
- clk  input  1  system clock. One clock; all state updates on the rising edge.
- reset  input  1  reset is asynchronous and active-low.
- class_led_0000_ext_red_led_exp  output  32  LED register; holds the last value written by an OUT instruction.

## Operation
- State:
  - pc[7:0].
  - Register file r0..r15, 32 bits each. r0 reads as 0; writes to r0 are ignored.
  - LED register led[31:0].
- Program ROM: 256 x 32, asynchronous read at pc. Unused words are NOP.
- Instruction format:
  - [31:28] opcode, [27:24] rd, [23:20] ra, [19:16] rb, [15:0] imm.
  - simm = sign-extended imm. tgt = imm[7:0].
- Opcodes. Every instruction sets pc <= pc+1 unless stated otherwise.
  - 0 NOP.
  - 1 LDI: rd <= simm.
  - 2 ADD: rd <= ra+rb.
  - 3 SUB: rd <= ra-rb.
  - 4 ADDI: rd <= ra+simm.
  - 5 AND, 6 OR, 7 XOR: rd <= ra op rb.
  - 8 OUT: led <= ra.
  - 9 JMP: pc <= tgt.
  - A BNZ: pc <= (ra!=0) ? tgt : pc+1.
  - B BZ: pc <= (ra==0) ? tgt : pc+1.
  - C..E: treated as NOP.
  - F HALT: pc holds; no state changes.
- Arithmetic is mod 2^32 with no flags. pc wraps 255 -> 0.
- Built-in program:
  - 0: LDI r1,0
  - 1: LDI r2,DELAY
  - 2: ADDI r2,r2,-1
  - 3: BNZ r2,2
  - 4: ADDI r1,r1,1
  - 5: OUT r1
  - 6: JMP 1
- Result: led shows 1, 2, 3, ... and wraps 0xFFFFFFFF -> 0.

## Timing
- Reset low (asynchronous):
  - pc=0, all registers=0, led=0, effective immediately.
  - Reset asserted mid-program aborts the current instruction. No partial writes.
- Exactly one instruction completes per rising edge while reset is high.
- Edge numbering: edge 1 is the first rising edge with reset high. It executes ROM[0].
- Built-in program schedule:
  - Edge 1: LDI r1.
  - Edge 2: LDI r2.
  - Edges 3..2+2*DELAY: delay loop.
  - Edge 3+2*DELAY: increment r1.
  - Edge 4+2*DELAY: led <= 1.
  - Edge 5+2*DELAY: JMP.
- LED period: led increments by exactly 1 every 2*DELAY+4 edges.
- With DELAY=4:
  - led=1 after edge 12, led=2 after edge 24, led=N after edge 12N.
- led changes only on OUT and otherwise holds. Output is registered, with no combinational path from inputs.
- Register write and read in the same instruction: read the old value. The write is visible on the next instruction.

## Test plan
- Reset value: hold reset low for 3 edges -> led=0 throughout and pc=0.
- First count, DELAY=4: release reset -> led stays 0 through edge 11, becomes 1 after edge 12, stays 1 through edge 23.
- Steady counting, DELAY=4: run 20000 edges -> led=N after edge 12N, never skips or repeats. Final value is 1666 at edge 20000.
- Parameter scaling: DELAY=1 -> led=1 after edge 6, then +1 every 6 edges.
- Mid-run reset: assert reset low between edges when led=5 -> led=0 immediately. After release, led=1 again after edge 12.
- ISA spot checks with alternate ROM contents, each -> the stated response:
  - LDI r3,-1 then ADDI r3,r3,2 then OUT r3 -> led=1.
  - SUB 0-1 -> 0xFFFFFFFF.
  - Writing r0 then OUT r0 -> led=0.
  - BZ taken/not-taken -> correct pc.
  - HALT freezes led.

Source files
------------

// File: rtl/simple_cpu.sv
// Single-cycle 32-bit demo CPU with a built-in program ROM; the only visible state is the
// memory-mapped LED register, which the default program drives with an up-counter.
module simple_cpu #(
  parameter int DELAY   = 4,  // delay-loop count loaded by the counter program (1..32767)
  parameter int PROGRAM = 0   // 0 = LED counter; 1..3 = short ISA exercise programs
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] class_led_0000_ext_red_led_exp
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_ADDI = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_OUT  = 4'h8,
    OP_JMP  = 4'h9,
    OP_BNZ  = 4'hA,
    OP_BZ   = 4'hB,
    OP_HALT = 4'hF
  } opcode_t;

  localparam logic [15:0] DELAY_IMM = 16'(DELAY);

  function automatic logic [31:0] enc(input opcode_t op, input logic [3:0] rd,
                                      input logic [3:0] ra, input logic [3:0] rb,
                                      input logic [15:0] imm);
    return {op, rd, ra, rb, imm};
  endfunction

  logic [7:0]  pc, pc_next;
  logic [31:0] regs [16];
  logic [31:0] led;
  logic [31:0] instr;

  // Program ROM: asynchronous read at pc, every unlisted word is a NOP.
  always_comb begin
    instr = enc(OP_NOP, 4'd0, 4'd0, 4'd0, 16'h0000);
    if (PROGRAM == 1) begin
      case (pc)
        8'd0: instr = enc(OP_LDI,  4'd3, 4'd0, 4'd0, 16'hFFFF);
        8'd1: instr = enc(OP_ADDI, 4'd3, 4'd3, 4'd0, 16'h0002);
        8'd2: instr = enc(OP_OUT,  4'd0, 4'd3, 4'd0, 16'h0000);
        8'd3: instr = enc(OP_LDI,  4'd1, 4'd0, 4'd0, 16'h0001);
        8'd4: instr = enc(OP_SUB,  4'd2, 4'd0, 4'd1, 16'h0000);
        8'd5: instr = enc(OP_OUT,  4'd0, 4'd2, 4'd0, 16'h0000);
        8'd6: instr = enc(OP_LDI,  4'd0, 4'd0, 4'd0, 16'h0005);
        8'd7: instr = enc(OP_OUT,  4'd0, 4'd0, 4'd0, 16'h0000);
        8'd8: instr = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'h0000);
        default: ;
      endcase
    end else if (PROGRAM == 2) begin
      case (pc)
        8'd0: instr = enc(OP_LDI,  4'd1, 4'd0, 4'd0, 16'h0001);
        8'd1: instr = enc(OP_BZ,   4'd0, 4'd1, 4'd0, 16'h0006);
        8'd2: instr = enc(OP_LDI,  4'd2, 4'd0, 4'd0, 16'h0011);
        8'd3: instr = enc(OP_OUT,  4'd0, 4'd2, 4'd0, 16'h0000);
        8'd4: instr = enc(OP_BZ,   4'd0, 4'd0, 4'd0, 16'h0007);
        8'd5: instr = enc(OP_OUT,  4'd0, 4'd1, 4'd0, 16'h0000);
        8'd6: instr = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'h0000);
        8'd7: instr = enc(OP_LDI,  4'd3, 4'd0, 4'd0, 16'h0033);
        8'd8: instr = enc(OP_OUT,  4'd0, 4'd3, 4'd0, 16'h0000);
        8'd9: instr = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'h0000);
        default: ;
      endcase
    end else if (PROGRAM == 3) begin
      case (pc)
        8'd0:  instr = enc(OP_LDI,  4'd1, 4'd0, 4'd0, 16'h0F0F);
        8'd1:  instr = enc(OP_LDI,  4'd2, 4'd0, 4'd0, 16'h00FF);
        8'd2:  instr = enc(OP_AND,  4'd3, 4'd1, 4'd2, 16'h0000);
        8'd3:  instr = enc(OP_OUT,  4'd0, 4'd3, 4'd0, 16'h0000);
        8'd4:  instr = enc(OP_OR,   4'd3, 4'd1, 4'd2, 16'h0000);
        8'd5:  instr = enc(OP_OUT,  4'd0, 4'd3, 4'd0, 16'h0000);
        8'd6:  instr = enc(OP_XOR,  4'd3, 4'd1, 4'd2, 16'h0000);
        8'd7:  instr = enc(OP_OUT,  4'd0, 4'd3, 4'd0, 16'h0000);
        8'd8:  instr = enc(OP_ADD,  4'd3, 4'd1, 4'd2, 16'h0000);
        8'd9:  instr = enc(OP_OUT,  4'd0, 4'd3, 4'd0, 16'h0000);
        8'd10: instr = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'h0000);
        8'd11: instr = enc(OP_OUT,  4'd0, 4'd1, 4'd0, 16'h0000);
        default: ;
      endcase
    end else begin
      case (pc)
        8'd0: instr = enc(OP_LDI,  4'd1, 4'd0, 4'd0, 16'h0000);
        8'd1: instr = enc(OP_LDI,  4'd2, 4'd0, 4'd0, DELAY_IMM);
        8'd2: instr = enc(OP_ADDI, 4'd2, 4'd2, 4'd0, 16'hFFFF);
        8'd3: instr = enc(OP_BNZ,  4'd0, 4'd2, 4'd0, 16'h0002);
        8'd4: instr = enc(OP_ADDI, 4'd1, 4'd1, 4'd0, 16'h0001);
        8'd5: instr = enc(OP_OUT,  4'd0, 4'd1, 4'd0, 16'h0000);
        8'd6: instr = enc(OP_JMP,  4'd0, 4'd0, 4'd0, 16'h0001);
        default: ;
      endcase
    end
  end

  opcode_t     op;
  logic [3:0]  rd;
  logic [31:0] va, vb, simm;
  logic [7:0]  tgt;
  logic        wr_en, led_wr;
  logic [31:0] wr_data;

  assign op   = opcode_t'(instr[31:28]);
  assign rd   = instr[27:24];
  // regs[0] is never written, so r0 reads as zero without a separate mux.
  assign va   = regs[instr[23:20]];
  assign vb   = regs[instr[19:16]];
  assign simm = {{16{instr[15]}}, instr[15:0]};
  assign tgt  = instr[7:0];

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    pc_next = pc + 8'd1;
    wr_en   = 1'b0;
    wr_data = '0;
    led_wr  = 1'b0;
    case (op)
      OP_LDI:  begin wr_en = 1'b1; wr_data = simm;     end
      OP_ADD:  begin wr_en = 1'b1; wr_data = va + vb;  end
      OP_SUB:  begin wr_en = 1'b1; wr_data = va - vb;  end
      OP_ADDI: begin wr_en = 1'b1; wr_data = va + simm; end
      OP_AND:  begin wr_en = 1'b1; wr_data = va & vb;  end
      OP_OR:   begin wr_en = 1'b1; wr_data = va | vb;  end
      OP_XOR:  begin wr_en = 1'b1; wr_data = va ^ vb;  end
      OP_OUT:  led_wr = 1'b1;
      OP_JMP:  pc_next = tgt;
      OP_BNZ:  if (va != '0) pc_next = tgt;
      OP_BZ:   if (va == '0) pc_next = tgt;
      OP_HALT: pc_next = pc;
      default: ;
    endcase
    if (rd == 4'd0) wr_en = 1'b0;
  end

  // NOTE: the 16-entry register file is reset in full because software relies on zeroed registers.
  // NOTE: all sequential state uses non-blocking assignments so reads see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= '0;
      led <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      pc <= pc_next;
      if (wr_en)  regs[rd] <= wr_data;
      if (led_wr) led <= va;
    end
  end

  assign class_led_0000_ext_red_led_exp = led;

endmodule

// File: tb/tb_simple_cpu.sv
// Directed bench for simple_cpu: counter timing at two DELAY values, reset behaviour and
// three ISA exercise programs, all checked against hand-derived LED values per edge.
module tb_simple_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] led_main, led_fast, led_isa1, led_isa2, led_isa3;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  simple_cpu #(.DELAY(4), .PROGRAM(0)) u_main (.clk(clk), .reset(reset), .class_led_0000_ext_red_led_exp(led_main));
  simple_cpu #(.DELAY(1), .PROGRAM(0)) u_fast (.clk(clk), .reset(reset), .class_led_0000_ext_red_led_exp(led_fast));
  simple_cpu #(.DELAY(4), .PROGRAM(1)) u_isa1 (.clk(clk), .reset(reset), .class_led_0000_ext_red_led_exp(led_isa1));
  simple_cpu #(.DELAY(4), .PROGRAM(2)) u_isa2 (.clk(clk), .reset(reset), .class_led_0000_ext_red_led_exp(led_isa2));
  simple_cpu #(.DELAY(4), .PROGRAM(3)) u_isa3 (.clk(clk), .reset(reset), .class_led_0000_ext_red_led_exp(led_isa3));

  task automatic step();
    @(posedge clk);
    #1;
    if (reset) edge_n++;
  endtask

  task automatic restart();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({led_main, led_fast, led_isa1, led_isa2, led_isa3} !== '0) begin
        n_bad++;
        $display("FAIL reset_hold cycle %0d: got main=%h fast=%h isa1=%h isa2=%h isa3=%h required all 0",
                 i, led_main, led_fast, led_isa1, led_isa2, led_isa3);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    edge_n = 0;
  endtask

  // Runs straight on from the reset release in test_reset.
  task automatic test_first_count();
    logic [31:0] exp;
    for (int e = 1; e <= 23; e++) begin
      step();
      exp = (e < 12) ? 32'd0 : 32'd1;
      n_cmp++;
      if (led_main !== exp) begin
        n_bad++;
        $display("FAIL first_count edge %0d: got %0d required %0d", edge_n, led_main, exp);
      end
    end
  endtask

  task automatic test_steady();
    logic [31:0] exp;
    while (edge_n < 20000) begin
      step();
      exp = 32'(edge_n / 12);
      n_cmp++;
      if (led_main !== exp) begin
        n_bad++;
        $display("FAIL steady edge %0d: got %0d required %0d", edge_n, led_main, exp);
      end
    end
    n_cmp++;
    if (led_main !== 32'd1666) begin
      n_bad++;
      $display("FAIL steady_final: got %0d required 1666", led_main);
    end
  endtask

  task automatic test_scaling();
    logic [31:0] exp;
    restart();
    for (int e = 1; e <= 60; e++) begin
      step();
      exp = 32'(e / 6);
      n_cmp++;
      if (led_fast !== exp) begin
        n_bad++;
        $display("FAIL scaling_delay1 edge %0d: got %0d required %0d", edge_n, led_fast, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    restart();
    repeat (60) step();
    n_cmp++;
    if (led_main !== 32'd5) begin
      n_bad++;
      $display("FAIL mid_reset_pre: got %0d required 5", led_main);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (led_main !== 32'd0) begin
      n_bad++;
      $display("FAIL mid_reset_async: got %0d required 0", led_main);
    end
    @(negedge clk);
    reset = 1'b1;
    edge_n = 0;
    repeat (11) step();
    n_cmp++;
    if (led_main !== 32'd0) begin
      n_bad++;
      $display("FAIL mid_reset_edge11: got %0d required 0", led_main);
    end
    step();
    n_cmp++;
    if (led_main !== 32'd1) begin
      n_bad++;
      $display("FAIL mid_reset_edge12: got %0d required 1", led_main);
    end
  endtask

  // LDI/ADDI with negative immediate, SUB wrap, r0 write ignored, then HALT.
  task automatic test_isa_arith();
    logic [31:0] exp;
    restart();
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e < 3)      exp = 32'h0000_0000;
      else if (e < 6) exp = 32'h0000_0001;
      else if (e < 8) exp = 32'hFFFF_FFFF;
      else            exp = 32'h0000_0000;
      n_cmp++;
      if (led_isa1 !== exp) begin
        n_bad++;
        $display("FAIL isa_arith edge %0d: got %h required %h", edge_n, led_isa1, exp);
      end
    end
  endtask

  // BZ not taken on r1=1, then taken on r0 over a decoy OUT.
  task automatic test_isa_branch();
    logic [31:0] exp;
    restart();
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e < 4)      exp = 32'h0000_0000;
      else if (e < 7) exp = 32'h0000_0011;
      else            exp = 32'h0000_0033;
      n_cmp++;
      if (led_isa2 !== exp) begin
        n_bad++;
        $display("FAIL isa_branch edge %0d: got %h required %h", edge_n, led_isa2, exp);
      end
    end
  endtask

  // AND/OR/XOR/ADD results, then HALT must block the OUT r1 that follows it.
  task automatic test_isa_logic_halt();
    logic [31:0] exp;
    restart();
    for (int e = 1; e <= 30; e++) begin
      step();
      if (e < 4)       exp = 32'h0000_0000;
      else if (e < 6)  exp = 32'h0000_000F;
      else if (e < 8)  exp = 32'h0000_0FFF;
      else if (e < 10) exp = 32'h0000_0FF0;
      else             exp = 32'h0000_100E;
      n_cmp++;
      if (led_isa3 !== exp) begin
        n_bad++;
        $display("FAIL isa_logic_halt edge %0d: got %h required %h", edge_n, led_isa3, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_count();
    test_steady();
    test_scaling();
    test_mid_reset();
    test_isa_arith();
    test_isa_branch();
    test_isa_logic_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
